// File: rtl/tdm_demux4_pkg.sv
// Shared types and sizing for the four-slot TDM demultiplexer.
package tdm_demux4_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;
  localparam int ERR_W  = 8;

endpackage

// File: rtl/tdm_demux4.sv
// Receive end of a 4-slot select-multiplexed link: locks to frame_sync,
// steers beats into channel registers and publishes whole frames atomically.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   frame_sync,
  input  logic                   resync,
  output logic [SLOTS-1:0]       ch_valid,
  output logic [SLOTS*WIDTH-1:0] ch_data,
  output logic [SLOTS*WIDTH-1:0] frame_q,
  output logic                   frame_valid,
  output logic                   locked,
  output logic                   sync_err,
  output logic [ERR_W-1:0]       err_cnt
);

  state_t                   state_reg, state_next;
  logic [SLOT_W-1:0]        slot_reg, slot_next;
  logic [WIDTH-1:0]         ch_data_reg [SLOTS];
  logic [WIDTH-1:0]         ch_data_next [SLOTS];
  logic [SLOTS*WIDTH-1:0]   frame_reg, frame_next;
  logic [SLOTS-1:0]         ch_valid_reg, ch_valid_next;
  logic                     frame_valid_reg, frame_valid_next;
  logic                     sync_err_reg, sync_err_next;
  logic [ERR_W-1:0]         err_reg, err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= HUNT;
      slot_reg        <= '0;
      frame_reg       <= '0;
      ch_valid_reg    <= '0;
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      err_reg         <= '0;
      for (int i = 0; i < SLOTS; i++) ch_data_reg[i] <= '0;
    end else begin
      state_reg       <= state_next;
      slot_reg        <= slot_next;
      frame_reg       <= frame_next;
      ch_valid_reg    <= ch_valid_next;
      frame_valid_reg <= frame_valid_next;
      sync_err_reg    <= sync_err_next;
      err_reg         <= err_next;
      for (int i = 0; i < SLOTS; i++) ch_data_reg[i] <= ch_data_next[i];
    end
  end

  always_comb begin
    state_next       = state_reg;
    slot_next        = slot_reg;
    frame_next       = frame_reg;
    ch_valid_next    = '0;
    frame_valid_next = 1'b0;
    sync_err_next    = 1'b0;
    err_next         = err_reg;
    for (int i = 0; i < SLOTS; i++) ch_data_next[i] = ch_data_reg[i];

    // resync takes priority over any beat presented in the same cycle
    if (resync) begin
      state_next = HUNT;
      slot_next  = '0;
    end else if (din_valid) begin
      case (state_reg)
        HUNT: begin
          if (frame_sync) begin
            state_next      = LOCKED;
            ch_data_next[0] = din;
            ch_valid_next   = 4'b0001;
            slot_next       = SLOT_W'(1);
          end
        end
        LOCKED: begin
          if (frame_sync && (slot_reg != '0)) begin
            // Misaligned marker: drop the partial frame and restart at slot 0
            sync_err_next   = 1'b1;
            if (err_reg != '1) err_next = err_reg + ERR_W'(1);
            ch_data_next[0] = din;
            ch_valid_next   = 4'b0001;
            slot_next       = SLOT_W'(1);
          end else begin
            ch_data_next[slot_reg] = din;
            ch_valid_next          = 4'b0001 << slot_reg;
            slot_next              = slot_reg + SLOT_W'(1);
            if (slot_reg == SLOT_W'(SLOTS - 1)) begin
              frame_next       = {din, ch_data_reg[2], ch_data_reg[1], ch_data_reg[0]};
              frame_valid_next = 1'b1;
            end
          end
        end
        default: begin
          state_next = HUNT;
          slot_next  = '0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_pack
      assign ch_data[gi*WIDTH +: WIDTH] = ch_data_reg[gi];
    end
  endgenerate

  assign ch_valid    = ch_valid_reg;
  assign frame_q     = frame_reg;
  assign frame_valid = frame_valid_reg;
  assign locked      = (state_reg == LOCKED);
  assign sync_err    = sync_err_reg;
  assign err_cnt     = err_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: frame-level reference model compared
// every cycle, plus literal expectations from the directed scenarios.
module tb_tdm_demux4;

  localparam int WIDTH = 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [WIDTH-1:0]   din = '0;
  logic               din_valid = 1'b0;
  logic               frame_sync = 1'b0;
  logic               resync = 1'b0;
  logic [3:0]         ch_valid;
  logic [4*WIDTH-1:0] ch_data;
  logic [4*WIDTH-1:0] frame_q;
  logic               frame_valid;
  logic               locked;
  logic               sync_err;
  logic [7:0]         err_cnt;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .resync      (resync),
    .ch_valid    (ch_valid),
    .ch_data     (ch_data),
    .frame_q     (frame_q),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: link position, channel contents and published frame
  bit               m_locked;
  int               m_pos;
  logic [WIDTH-1:0] m_ch [4];
  logic [WIDTH-1:0] m_frame [4];
  logic [3:0]       m_chv;
  bit               m_fv;
  bit               m_se;
  int               m_err;

  // Literal expectations pinned by the directed scenarios
  bit               pin_fq_en, pin_err_en, pin_chv_en, pin_lock_en;
  logic [4*WIDTH-1:0] pin_fq;
  int               pin_err;
  logic [3:0]       pin_chv;
  bit               pin_lock;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [4*WIDTH-1:0] pack4(input logic [WIDTH-1:0] a [4]);
    return {a[3], a[2], a[1], a[0]};
  endfunction

  task automatic model_reset();
    m_locked = 0;
    m_pos    = 0;
    m_chv    = '0;
    m_fv     = 0;
    m_se     = 0;
    m_err    = 0;
    for (int i = 0; i < 4; i++) begin
      m_ch[i]    = '0;
      m_frame[i] = '0;
    end
  endtask

  task automatic model_take(input int k, input logic [WIDTH-1:0] d);
    m_ch[k] = d;
    m_chv   = 4'(1 << k);
    m_pos   = (k + 1) % 4;
    if (k == 3) begin
      for (int i = 0; i < 4; i++) m_frame[i] = m_ch[i];
      m_fv = 1;
    end
  endtask

  task automatic model_step(input bit v, input bit s, input bit r, input logic [WIDTH-1:0] d);
    m_chv = '0;
    m_fv  = 0;
    m_se  = 0;
    if (r) begin
      m_locked = 0;
      m_pos    = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1;
          model_take(0, d);
        end
      end else if (s && m_pos != 0) begin
        m_se  = 1;
        m_err = (m_err < 255) ? m_err + 1 : 255;
        model_take(0, d);
      end else begin
        model_take(m_pos, d);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ch_valid",    32'(ch_valid),    32'(m_chv));
    chk("ch_data",     32'(ch_data),     32'(pack4(m_ch)));
    chk("frame_q",     32'(frame_q),     32'(pack4(m_frame)));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("locked",      32'(locked),      32'(m_locked));
    chk("sync_err",    32'(sync_err),    32'(m_se));
    chk("err_cnt",     32'(err_cnt),     32'(m_err));
    if (pin_fq_en)   chk("pin_frame_q",  32'(frame_q),  32'(pin_fq));
    if (pin_err_en)  chk("pin_err_cnt",  32'(err_cnt),  32'(pin_err));
    if (pin_chv_en)  chk("pin_ch_valid", 32'(ch_valid), 32'(pin_chv));
    if (pin_lock_en) chk("pin_locked",   32'(locked),   32'(pin_lock));
  end

  // Present one cycle of inputs; returns 1ns after the accepting edge
  task automatic step(input bit v, input bit s, input bit r, input logic [WIDTH-1:0] d);
    pin_fq_en   = 0;
    pin_err_en  = 0;
    pin_chv_en  = 0;
    pin_lock_en = 0;
    din_valid   = v;
    frame_sync  = s;
    resync      = r;
    din         = d;
    @(posedge clk);
    model_step(v, s, r, d);
    #1;
  endtask

  task automatic beat(input bit s, input logic [WIDTH-1:0] d);
    step(1'b1, s, 1'b0, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0; frame_sync = 1'b0; resync = 1'b0; din = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    pin_fq_en = 0; pin_err_en = 0; pin_chv_en = 0; pin_lock_en = 0;
    pin_fq = '0; pin_err = 0; pin_chv = '0; pin_lock = 0;
    model_reset();
    do_reset();
    pin_fq_en = 1; pin_fq = 4'b0000; pin_err_en = 1; pin_err = 0;
    pin_lock_en = 1; pin_lock = 0;

    // Acquire and collect one frame back-to-back
    beat(1, 1'b1);
    pin_chv_en = 1; pin_chv = 4'b0001; pin_lock_en = 1; pin_lock = 1;
    beat(0, 1'b0);
    pin_chv_en = 1; pin_chv = 4'b0010;
    beat(0, 1'b1);
    pin_chv_en = 1; pin_chv = 4'b0100;
    beat(0, 1'b1);
    pin_chv_en = 1; pin_chv = 4'b1000; pin_fq_en = 1; pin_fq = 4'b1101;
    idle(1);

    // Beats before the first marker are dropped
    do_reset();
    beat(0, 1'b1);
    beat(0, 1'b1);
    pin_lock_en = 1; pin_lock = 0;
    beat(1, 1'b0); beat(0, 1'b1); beat(0, 1'b1); beat(0, 1'b0);
    pin_fq_en = 1; pin_fq = 4'b0110; pin_err_en = 1; pin_err = 0;
    idle(1);

    // Marker arriving at slot 2 realigns and discards the partial frame
    beat(0, 1'b1); beat(0, 1'b1);
    beat(1, 1'b1);
    pin_err_en = 1; pin_err = 1; pin_chv_en = 1; pin_chv = 4'b0001;
    beat(0, 1'b0); beat(0, 1'b0); beat(0, 1'b1);
    pin_fq_en = 1; pin_fq = 4'b1001;
    idle(1);

    // Gapped stream
    beat(0, 1'b1); idle(3);
    beat(0, 1'b1); idle(3);
    beat(0, 1'b1); idle(3);
    beat(0, 1'b0);
    pin_fq_en = 1; pin_fq = 4'b0111; pin_chv_en = 1; pin_chv = 4'b1000;
    idle(2);

    // resync with a concurrent beat after slot 1
    beat(0, 1'b0); beat(0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    pin_lock_en = 1; pin_lock = 0; pin_fq_en = 1; pin_fq = 4'b0111;
    beat(0, 1'b1);
    pin_lock_en = 1; pin_lock = 0;
    beat(1, 1'b0); beat(0, 1'b0); beat(0, 1'b1); beat(0, 1'b1);
    pin_fq_en = 1; pin_fq = 4'b1100; pin_lock_en = 1; pin_lock = 1;

    // Asynchronous reset after slot 2, mid-cycle
    beat(0, 1'b1); beat(0, 1'b1); beat(0, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_frame_q", 32'(frame_q), 32'(0));
    chk("async_rst_locked",  32'(locked),  32'(0));
    chk("async_rst_ch_data", 32'(ch_data), 32'(0));
    do_reset();

    // Saturating error counter
    beat(1, 1'b0);
    for (int i = 0; i < 300; i++) beat(1, 1'($urandom));
    pin_err_en = 1; pin_err = 255; pin_lock_en = 1; pin_lock = 1;
    idle(1);

    // Randomized traffic with occasional resync and one async reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst_n = 1'b0;
        model_reset();
        do_reset();
      end
      step(($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 49) == 0),
           WIDTH'($urandom));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-slot time-division demultiplexer: the receive end of the 4-to-1 select-multiplexed link. A transmitter steps its 2-bit select through slots 0..3 and drives one slot per beat. This block realigns to the frame marker, steers each beat into its channel register, and presents the whole frame atomically with a one-cycle strobe. It sits between the serial link and the per-channel consumers.

## Interface
Parameters:
- WIDTH, 1, bits per slot/channel

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- din  input  WIDTH  slot data from link
- din_valid  input  1  beat qualifier; one slot consumed per accepted beat
- frame_sync  input  1  marks current beat as slot 0; ignored when din_valid=0
- resync  input  1  synchronous: force HUNT, discard partial frame
- ch_valid  output  4  one-hot strobe, bit k = slot k captured last cycle
- ch_data  output  4*WIDTH  live per-slot registers, slot k at [k*WIDTH +: WIDTH]
- frame_q  output  4*WIDTH  last complete frame, same packing, updated atomically
- frame_valid  output  1  one-cycle pulse when frame_q updates
- locked  output  1  1 in LOCKED state
- sync_err  output  1  one-cycle pulse on misaligned frame_sync
- err_cnt  output  8  saturating count of sync_err events

## Operation
- Reset: state HUNT; slot_cnt=0; ch_data, frame_q, ch_valid, frame_valid, locked, sync_err, err_cnt all 0.
- HUNT: beats without frame_sync dropped. Beat with frame_sync -> ch_data[0]<=din, ch_valid<=0001, slot_cnt<=1, go LOCKED.
- LOCKED, accepted beat (din_valid=1):
  - frame_sync=0, or frame_sync=1 with slot_cnt=0: ch_data[slot_cnt]<=din, ch_valid<=one-hot(slot_cnt), slot_cnt<=slot_cnt+1 (mod 4). Sync only required to acquire lock; absence at slot 0 is legal.
  - frame_sync=1 with slot_cnt!=0: misalignment. sync_err pulses; err_cnt increments (saturate at 255); partial frame discarded (no frame_valid); beat taken as slot 0 (ch_data[0]<=din, ch_valid<=0001, slot_cnt<=1); remain LOCKED.
  - slot_cnt=3 accepted: frame_q<={din, ch_data[2], ch_data[1], ch_data[0]} (slot 3 in MSBs), frame_valid pulses, slot_cnt wraps to 0.
- din_valid=0: no state change; strobes deassert.
- resync=1: next state HUNT, slot_cnt=0, locked=0; ch_data and frame_q retain values; concurrent beat dropped (resync wins). err_cnt not cleared (reset only).
- ch_data slots not written in the current frame hold previous values.

## Timing
- All outputs registered; ch_valid, ch_data, frame_q, frame_valid, sync_err, locked update on the clock edge that accepts the beat, visible one cycle later.
- Frame latency: frame_valid high the cycle after slot-3 beat edge, coincident with ch_valid=1000.
- Back-to-back beats every cycle supported; throughput one slot/cycle, one frame per 4 accepted beats.
- Gaps (din_valid=0) any length between beats; slot alignment preserved.
- rst_n assertion mid-frame clears immediately (asynchronous); deassertion begins in HUNT.
- locked rises the cycle after the acquiring sync beat, falls the cycle after resync.

## Structure
- Shared package: state enum {HUNT, LOCKED}, SLOTS=4, SLOT_W=2, ERR_W=8.
- Single module; two-state FSM, slot counter, and capture registers are small enough that no sub-module is warranted.

## Test plan
- Reset then sync frame, WIDTH=1: beats din=1(sync),0,1,1 back-to-back -> ch_valid 0001,0010,0100,1000; frame_valid one cycle with ch_valid=1000; frame_q=4'b1101; locked=1.
- HUNT drop: din=1,1 without sync, then sync frame 0,1,1,0 -> first two dropped, frame_q=4'b0110, err_cnt=0.
- Misaligned sync: after slots 0,1 accepted, sync beat din=1 -> sync_err pulse, err_cnt=1, no frame_valid, ch_valid=0001; next three beats 0,0,1 -> frame_q=4'b1001.
- Gapped stream: frame 1,1,1,0 with din_valid low 3 cycles between each beat -> same strobes in order, frame_q=4'b0111, no spurious strobes in gaps.
- resync with din_valid mid-frame after slot 1 -> beat dropped, locked=0 next cycle, ch_data/frame_q unchanged; subsequent sync frame re-locks.
- Async reset mid-frame (after slot 2) -> all outputs 0 immediately, err_cnt=0; 300 misaligned syncs -> err_cnt saturates at 255.
